// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding and requester IDs.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requester IDs double as bit positions in the request vector.
    typedef enum logic {
        GNT_D  = 1'b0,
        GNT_IF = 1'b1
    } gnt_t;

    // The port that should win the next conflict after g has won this one.
    function automatic gnt_t gnt_other(input gnt_t g);
        return (g == GNT_D) ? GNT_IF : GNT_D;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a conflict the pointer names the winner;
// otherwise the single requester wins. Output is only meaningful when |req.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       ptr,
    output gnt_t       grant
);

    // Pick the winner: pointer breaks ties, lone requester wins outright.
    always_comb begin
        grant = GNT_D;
        if (req[GNT_IF] && req[GNT_D]) begin
            grant = ptr;
        end else if (req[GNT_IF]) begin
            grant = GNT_IF;
        end else begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory.
// Each access is latched in IDLE, held for LATENCY BUSY cycles, and completes
// with a one-cycle done pulse in the last BUSY cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,

    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,

    input  logic        createdump,
    output logic        mem_createdump,

    output logic        busy
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic               lat_wr;
    gnt_t               lat_gnt;
    gnt_t               rr_ptr;

    logic [1:0]         req_vec;
    gnt_t               grant;
    logic               load;
    logic               conflict;
    logic               active;
    logic               last;

    assign req_vec  = {if_req, d_req};
    assign conflict = if_req & d_req;

    rr_arb2 u_rr_arb2 (
        .req   (req_vec),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Next-state: requests are only looked at in IDLE; BUSY runs to cnt==0.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    state_nxt = BUSY;
                    load      = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the latched access and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            lat_gnt   <= GNT_D;
            rr_ptr    <= GNT_D;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt       <= CNT_W'(LATENCY - 1);
                lat_gnt   <= grant;
                if (grant == GNT_IF) begin
                    lat_addr  <= if_addr;
                    lat_wdata <= '0;
                    lat_wr    <= 1'b0;
                end else begin
                    lat_addr  <= d_addr;
                    lat_wdata <= d_wdata;
                    lat_wr    <= d_wr;
                end
                // Pointer only moves when both ports actually contended.
                if (conflict) begin
                    rr_ptr <= gnt_other(grant);
                end
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Memory-side and port-side outputs; reset masks everything that could
    // cause a write or a completion during the memory's load cycle.
    always_comb begin
        active         = (state == BUSY) && !rst;
        last           = active && (cnt == '0);

        mem_enable     = active;
        mem_wr         = last && lat_wr;
        mem_addr       = active ? lat_addr  : '0;
        mem_data_in    = active ? lat_wdata : '0;

        if_done        = last && (lat_gnt == GNT_IF);
        d_done         = last && (lat_gnt == GNT_D);
        if_rdata       = if_done ? mem_data_out : '0;
        d_rdata        = (d_done && !lat_wr) ? mem_data_out : '0;

        if_stall       = if_req & ~if_done;
        d_stall        = d_req & ~d_done;

        mem_createdump = createdump & ~rst;
        busy           = (state == BUSY);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LATENCY=2 and a small behavioural memory.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_wr, createdump;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
    logic        if_done, if_stall, d_done, d_stall;
    logic        mem_enable, mem_wr, mem_createdump, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .createdump(createdump), .mem_createdump(mem_createdump),
        .busy(busy)
    );

    // Behavioural memory: word-indexed, combinational read, plus a bench
    // back-door write port used only for preloading.
    logic [15:0] mem [0:1023];
    logic        tb_we = 1'b0;
    logic [15:0] tb_waddr = '0, tb_wdata = '0;

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[10:1]] <= mem_data_in;
        else if (tb_we)           mem[tb_waddr[10:1]] <= tb_wdata;
    end
    assign mem_data_out = mem[mem_addr[10:1]];

    // Free-running event counters; sequences look at deltas.
    int wr_pulses = 0, if_pulses = 0, d_pulses = 0;
    always @(posedge clk) begin
        if (mem_enable && mem_wr) wr_pulses++;
        if (if_done)              if_pulses++;
        if (d_done)               d_pulses++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    typedef struct {
        logic        is_if;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // One isolated access: latency, read data, address, write count, bubble.
    task automatic run_vec(input int i);
        vec_t v;
        int   cyc, w0, i0, d0;
        logic got;
        v = vecs[i];
        @(negedge clk);
        w0 = wr_pulses; i0 = if_pulses; d0 = d_pulses;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end
        #1;
        chk($sformatf("v%0d stall_on_req", i), v.is_if ? if_stall : d_stall, 1);
        cyc = 1;
        got = v.is_if ? if_done : d_done;
        while (!got && cyc < 10) begin
            @(negedge clk); #1;
            cyc++;
            got = v.is_if ? if_done : d_done;
        end
        chk($sformatf("v%0d latency", i), cyc, LAT + 1);
        chk($sformatf("v%0d rdata", i), v.is_if ? if_rdata : d_rdata, v.exp_rdata);
        chk($sformatf("v%0d mem_addr", i), mem_addr, v.addr);
        chk($sformatf("v%0d stall_at_done", i), v.is_if ? if_stall : d_stall, 0);
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk); #1;
        chk($sformatf("v%0d bubble_idle", i), busy, 0);
        chk($sformatf("v%0d write_count", i), wr_pulses - w0, v.wr);
        chk($sformatf("v%0d if_pulses", i), if_pulses - i0, v.is_if);
        chk($sformatf("v%0d d_pulses", i), d_pulses - d0, !v.is_if);
    endtask

    initial begin
        int   n, cyc, w0, d0;
        logic [1:0] order [4];
        logic [15:0] rd;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[1] = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 16'h0020, 16'hCAFE, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hCAFE};
        vecs[6] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h5A5A};

        rst = 1'b1; createdump = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state, with preloading done while the arbiter is held off.
        preload(16'h0010, 16'h1234);
        preload(16'h0004, 16'h5A5A);
        preload(16'h0200, 16'h1111);
        #1;
        chk("rst mem_createdump", mem_createdump, 0);
        chk("rst mem_enable", mem_enable, 0);
        chk("rst busy", busy, 0);
        chk("rst dones", {if_done, d_done}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst stalls", {if_stall, d_stall}, 0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("createdump pass", mem_createdump, 1);
        createdump = 1'b0; #1;
        chk("createdump low", mem_createdump, 0);

        // Single-port accesses from the table.
        for (int i = 0; i < 7; i++) run_vec(i);

        // Both ports held for four accesses: D, IF, D, IF.
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0004;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            #1;
            if (d_done) begin
                order[n] = 2'd0;
                chk($sformatf("rr%0d d_rdata", n), d_rdata, 16'h5A5A);
                n++;
            end else if (if_done) begin
                order[n] = 2'd1;
                chk($sformatf("rr%0d if_rdata", n), if_rdata, 16'h1234);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("rr completions", n, 4);
        for (int k = 0; k < n; k++)
            chk($sformatf("rr%0d grant", k), order[k], (k % 2 == 0) ? 2'd0 : 2'd1);
        @(negedge clk); @(negedge clk);

        // Reset in the final BUSY cycle of a write aborts it.
        @(negedge clk);
        w0 = wr_pulses; d0 = d_pulses;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h9999;
        @(negedge clk); #1;
        chk("abort busy", busy, 1);
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0; d_wr = 1'b0; #1;
        chk("abort mem_wr forced", mem_wr, 0);
        chk("abort mem_enable forced", mem_enable, 0);
        chk("abort d_done forced", d_done, 0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("abort busy after rst", busy, 0);
        @(negedge clk); #1;
        chk("abort mem unchanged", mem[16'h0200 >> 1], 16'h1111);
        chk("abort no write", wr_pulses - w0, 0);
        chk("abort no done", d_pulses - d0, 0);

        // Request dropped (and address changed) after the grant.
        @(negedge clk);
        d0 = d_pulses; rd = '0;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0004;
        @(negedge clk);
        d_req = 1'b0; d_addr = 16'h0010;
        cyc = 0;
        while ((d_pulses - d0) < 1 && cyc < 10) begin
            #1;
            if (d_done) rd = d_rdata;
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("drop d_done once", d_pulses - d0, 1);
        chk("drop rdata", rd, 16'h5A5A);
        chk("drop back to idle", busy, 0);
        @(negedge clk); @(negedge clk); #1;
        chk("drop no extra done", d_pulses - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
